// File: rtl/uart_bus_slave.sv
// rtl/uart_bus_slave.sv - memory-mapped 8N1 UART with strobed register bus and 4-entry RX FIFO
// Register reads/writes are acked one cycle after acceptance; RX bytes queue until read.
module uart_bus_slave #(
  parameter int BAUD_DIV   = 217,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        addr_i,
  input  logic [7:0]  data_i,
  input  logic        we_i,
  input  logic        stb_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        uart_TxD,
  input  logic        uart_RxD,
  output logic        irq_o
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;
  localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic        ack_q;
  logic [31:0] rdata_q, rdata_d;
  logic        accept, wr_data, rd_data, rd_status;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [NW-1:0] count_q;
  logic          fifo_full, fifo_empty, push, pop;
  logic          overrun_q, overrun_d, frame_err_q, frame_err_d;

  state_e      tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        txd_q, txd_d, tx_ready;

  state_e      rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic        rx_done, rx_ferr;

  assign accept    = stb_i & ~ack_q;
  assign wr_data   = accept & we_i & ~addr_i;
  assign rd_data   = accept & ~we_i & ~addr_i;
  assign rd_status = accept & ~we_i & addr_i;

  assign fifo_full  = (count_q == NW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign pop        = rd_data & ~fifo_empty;
  // A same-cycle pop frees the slot the incoming byte needs.
  assign push       = rx_done & (~fifo_full | pop);
  assign tx_ready   = (tx_state_q == S_IDLE);

  assign overrun_d   = (overrun_q & ~rd_status) | (rx_done & fifo_full & ~pop);
  assign frame_err_d = (frame_err_q & ~rd_status) | rx_ferr;

  always_comb begin
    rdata_d = '0;
    if (rd_data && !fifo_empty) rdata_d = {24'b0, mem_q[rptr_q]};
    if (rd_status) rdata_d = {25'b0, 3'(count_q), frame_err_q, overrun_q, ~fifo_empty, tx_ready};
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    txd_d      = txd_q;
    if (tx_state_q != S_IDLE) tx_cnt_d = tx_cnt_q + CW'(1);
    unique case (tx_state_q)
      S_IDLE: if (wr_data) begin
        tx_state_d = S_START;
        tx_cnt_d   = '0;
        tx_sh_d    = data_i;
        txd_d      = 1'b0;
      end
      S_START: if (tx_cnt_q == BIT_END) begin
        tx_state_d = S_DATA;
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        txd_d      = tx_sh_q[0];
      end
      S_DATA: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = S_STOP;
          txd_d      = 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 3'd1;
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          txd_d    = tx_sh_q[1];
        end
      end
      S_STOP: if (tx_cnt_q == BIT_END) begin
        tx_state_d = S_IDLE;
        tx_cnt_d   = '0;
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_done    = 1'b0;
    rx_ferr    = 1'b0;
    if (rx_state_q != S_IDLE) rx_cnt_d = rx_cnt_q + CW'(1);
    unique case (rx_state_q)
      S_IDLE: if (rx_prev_q && !rx_s2_q) begin
        rx_state_d = S_START;
        rx_cnt_d   = '0;
      end
      S_START: if (rx_cnt_q == HALF_END) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_cnt_q == BIT_END) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
        else                  rx_bit_d   = rx_bit_q + 3'd1;
      end
      S_STOP: if (rx_cnt_q == BIT_END) begin
        rx_state_d = S_IDLE;
        rx_cnt_d   = '0;
        rx_done    = rx_s2_q;
        rx_ferr    = ~rx_s2_q;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      tx_state_q  <= S_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_sh_q     <= '0;
      txd_q       <= 1'b1;
      rx_state_q  <= S_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
    end else begin
      ack_q       <= accept;
      rdata_q     <= rdata_d;
      wptr_q      <= wptr_q + PW'(push);
      rptr_q      <= rptr_q + PW'(pop);
      count_q     <= count_q + NW'(push) - NW'(pop);
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_sh_q     <= tx_sh_d;
      txd_q       <= txd_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_sh_q     <= rx_sh_d;
      rx_s1_q     <= uart_RxD;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_s2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= rx_sh_q;
  end

  assign data_o   = rdata_q;
  assign ack_o    = ack_q;
  assign uart_TxD = txd_q;
  assign irq_o    = ~fifo_empty;

endmodule

// File: tb/tb_uart_bus_slave.sv
// tb/tb_uart_bus_slave.sv - directed self-checking bench for uart_bus_slave
// Register vectors from a table, then hand-timed TX/RX/FIFO sequences at BAUD_DIV=4.
module tb_uart_bus_slave;

  localparam int BAUD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        addr_i = 1'b0;
  logic [7:0]  data_i = 8'h00;
  logic        we_i = 1'b0;
  logic        stb_i = 1'b0;
  logic [31:0] data_o;
  logic        ack_o;
  logic        uart_TxD;
  logic        uart_RxD = 1'b1;
  logic        irq_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        addr;
    logic        we;
    logic [7:0]  wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [8];
  logic        cap [44];
  logic [31:0] rd;
  logic        ak;
  logic [9:0]  txf;

  uart_bus_slave #(.BAUD_DIV(BAUD), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .addr_i(addr_i), .data_i(data_i), .we_i(we_i), .stb_i(stb_i),
    .data_o(data_o), .ack_o(ack_o), .uart_TxD(uart_TxD), .uart_RxD(uart_RxD), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after an edge; accepts at the next edge, samples in the ack cycle.
  task automatic bus_xfer(input logic a, input logic w, input logic [7:0] d,
                          output logic [31:0] rdat, output logic ackv);
    addr_i = a;
    we_i   = w;
    data_i = d;
    stb_i  = 1'b1;
    tick();
    rdat  = data_o;
    ackv  = ack_o;
    stb_i = 1'b0;
    tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_RxD = fr[i];
      repeat (BAUD) tick();
    end
    uart_RxD = 1'b1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 8'h00, 32'h0000_0001};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 32'h0000_0000};
    vecs[2] = '{1'b1, 1'b1, 8'hFF, 32'h0000_0000};
    vecs[3] = '{1'b1, 1'b0, 8'h00, 32'h0000_0001};
    vecs[4] = '{1'b0, 1'b1, 8'hC3, 32'h0000_0000};
    vecs[5] = '{1'b1, 1'b0, 8'h00, 32'h0000_0000};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 32'h0000_0000};
    vecs[7] = '{1'b1, 1'b0, 8'h00, 32'h0000_0000};

    for (int c = 0; c < 3; c++) begin
      addr_i   = 1'($urandom_range(0, 1));
      we_i     = 1'($urandom_range(0, 1));
      stb_i    = 1'($urandom_range(0, 1));
      data_i   = 8'($urandom_range(0, 255));
      uart_RxD = 1'($urandom_range(0, 1));
      @(posedge clk);
    end
    @(negedge clk);
    check("rst_txd",  {31'b0, uart_TxD}, 32'd1);
    check("rst_ack",  {31'b0, ack_o},    32'd0);
    check("rst_data", data_o,            32'd0);
    check("rst_irq",  {31'b0, irq_o},    32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; stb_i = 1'b0; we_i = 1'b0; addr_i = 1'b0; uart_RxD = 1'b1;
    tick();

    for (int v = 0; v < 8; v++) begin
      bus_xfer(vecs[v].addr, vecs[v].we, vecs[v].wdata, rd, ak);
      check($sformatf("vec%0d_data", v), rd, vecs[v].exp);
      check($sformatf("vec%0d_ack", v), {31'b0, ak}, 32'd1);
    end
    repeat (45) tick();

    // TX 0x55 with a dropped write mid-frame and tx_ready probes around frame end
    txf = {1'b1, 8'h55, 1'b0};
    fork
      begin
        bus_xfer(1'b0, 1'b1, 8'h55, rd, ak);
        repeat (8) tick();
        bus_xfer(1'b0, 1'b1, 8'hFF, rd, ak);
        check("tx_drop_ack", {31'b0, ak}, 32'd1);
        repeat (27) tick();
        bus_xfer(1'b1, 1'b0, 8'h00, rd, ak);
        check("tx_busy_e39", rd, 32'h0000_0000);
        bus_xfer(1'b1, 1'b0, 8'h00, rd, ak);
        check("tx_ready_e41", rd, 32'h0000_0001);
      end
      begin
        @(posedge clk);
        for (int i = 0; i < 44; i++) begin
          @(negedge clk);
          cap[i] = uart_TxD;
        end
      end
    join
    for (int i = 0; i < 44; i++)
      check($sformatf("tx_bit_c%0d", i), {31'b0, cap[i]}, {31'b0, (i < 40) ? txf[i / BAUD] : 1'b1});
    repeat (4) tick();

    // RX 0xA3 with TX kept busy so tx_ready reads 0
    send_frame(8'hA3, 1'b1);
    repeat (4) tick();
    check("rx_irq_set", {31'b0, irq_o}, 32'd1);
    bus_xfer(1'b0, 1'b1, 8'h00, rd, ak);
    bus_xfer(1'b1, 1'b0, 8'h00, rd, ak);
    check("rx_status", rd, 32'h0000_0012);
    bus_xfer(1'b0, 1'b0, 8'h00, rd, ak);
    check("rx_data", rd, 32'h0000_00A3);
    check("rx_irq_clr", {31'b0, irq_o}, 32'd0);
    bus_xfer(1'b0, 1'b0, 8'h00, rd, ak);
    check("rx_empty_read", rd, 32'h0000_0000);
    repeat (45) tick();

    // Overrun: fifth frame dropped
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 1'b1);
      repeat (4) tick();
    end
    bus_xfer(1'b0, 1'b1, 8'h00, rd, ak);
    bus_xfer(1'b1, 1'b0, 8'h00, rd, ak);
    check("ovr_status", rd, 32'h0000_0046);
    for (int k = 1; k <= 4; k++) begin
      bus_xfer(1'b0, 1'b0, 8'h00, rd, ak);
      check($sformatf("ovr_data%0d", k), rd, 32'(k));
    end
    bus_xfer(1'b1, 1'b0, 8'h00, rd, ak);
    check("ovr_cleared", rd, 32'h0000_0000);
    repeat (45) tick();

    // Framing error, then a 1-cycle glitch
    send_frame(8'h7E, 1'b0);
    repeat (4) tick();
    check("ferr_irq", {31'b0, irq_o}, 32'd0);
    bus_xfer(1'b1, 1'b0, 8'h00, rd, ak);
    check("ferr_status", rd, 32'h0000_0009);
    bus_xfer(1'b1, 1'b0, 8'h00, rd, ak);
    check("ferr_cleared", rd, 32'h0000_0001);
    uart_RxD = 1'b0;
    tick();
    uart_RxD = 1'b1;
    repeat (20) tick();
    bus_xfer(1'b1, 1'b0, 8'h00, rd, ak);
    check("glitch_status", rd, 32'h0000_0001);

    // Full FIFO: pop lands on the same edge as the stop-bit push
    for (int k = 0; k < 4; k++) begin
      send_frame(8'h11 + 8'(k), 1'b1);
      repeat (4) tick();
    end
    fork
      send_frame(8'h15, 1'b1);
      begin
        repeat (40) tick();
        bus_xfer(1'b0, 1'b0, 8'h00, rd, ak);
        check("sim_pop", rd, 32'h0000_0011);
      end
    join
    tick();
    bus_xfer(1'b1, 1'b0, 8'h00, rd, ak);
    check("sim_status", rd, 32'h0000_0043);
    for (int k = 0; k < 4; k++) begin
      bus_xfer(1'b0, 1'b0, 8'h00, rd, ak);
      check($sformatf("sim_data%0d", k), rd, 32'h12 + 32'(k));
    end
    bus_xfer(1'b1, 1'b0, 8'h00, rd, ak);
    check("sim_final", rd, 32'h0000_0001);

    // Reset mid-frame aborts TX and flushes the FIFO
    send_frame(8'h5A, 1'b1);
    repeat (4) tick();
    bus_xfer(1'b0, 1'b1, 8'h81, rd, ak);
    check("mid_txd_start", {31'b0, uart_TxD}, 32'd0);
    rst = 1'b1;
    tick();
    check("mid_txd_rst", {31'b0, uart_TxD}, 32'd1);
    check("mid_irq_rst", {31'b0, irq_o}, 32'd0);
    rst = 1'b0;
    bus_xfer(1'b1, 1'b0, 8'h00, rd, ak);
    check("mid_status", rd, 32'h0000_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_bus_slave.md
# uart_bus_slave

Memory-mapped UART peripheral that sits directly behind `bus_top` on the UART slot of the SoC bus and drives the board `com_TxD`/`com_RxD` pins. It accepts single-cycle strobed register accesses from the bus decoder and transmits bytes in 8N1 framing. Received bytes are buffered in a 4-entry FIFO, and an interrupt level is raised while received data is pending.

## Interface
- `BAUD_DIV`, 217: clock cycles per UART bit; must be ≥ 4 and even.
- `FIFO_DEPTH`, 4: RX FIFO entries; power of two.
- `clk` in 1: the single clock for the block.
- `rst` in 1: synchronous reset, active-high.
- `addr_i` in 1: register select; 0 = DATA, 1 = STATUS.
- `data_i` in 8: write data; only DATA writes use it.
- `we_i` in 1: 1 = write, 0 = read; qualified by `stb_i`.
- `stb_i` in 1: access request; held high by the master until `ack_o`.
- `data_o` out 32: read data; valid only in the `ack_o` cycle, 0 otherwise.
- `ack_o` out 1: one-cycle access acknowledge.
- `uart_TxD` out 1: serial output; idle high.
- `uart_RxD` in 1: serial input; asynchronous.
- `irq_o` out 1: high while the RX FIFO is non-empty.

## Operation
**Registers**
- **DATA write:**
  - If `tx_ready`=1, load `data_i` into the TX shifter and start a frame.
  - If busy, drop the byte silently; the access is still acked.
- **DATA read:**
  - Returns `{24'b0, fifo_head}` and pops the FIFO.
  - If the FIFO is empty, returns 0 and does not pop.
- **STATUS read:**
  - Bit 0 = `tx_ready`, bit 1 = `rx_valid`, bit 2 = `overrun`, bit 3 = `frame_err`, bits [6:4] = FIFO count, other bits 0.
  - The read clears `overrun` and `frame_err`. An event in the same cycle sets the bit again.
- **STATUS write:** ignored; acked.

**Bus handshake**
- An access is accepted in a cycle with `stb_i`=1 and `ack_o`=0.
- `ack_o`=1 in the next cycle, for exactly one cycle.
- Side effects (TX load, pop, sticky clear) take effect at the accepting edge.
- `stb_i` still high in the ack cycle is not a new request. The next request is accepted no earlier than the cycle after ack.

**TX FSM** (IDLE → START → DATA → STOP → IDLE)
- START drives 0; DATA drives bits LSB first, 8 bits; STOP drives 1.
- Every state lasts `BAUD_DIV` cycles.
- `tx_ready` goes 0 at the accepting edge and returns to 1 when STOP completes.

**RX FSM** (IDLE → START → DATA → STOP → IDLE)
- `uart_RxD` passes through a 2-flop synchronizer before use.
- IDLE: a falling edge on the synchronized input moves to START.
- START: wait `BAUD_DIV/2` cycles, then resample.
  - High is a glitch: return to IDLE, nothing recorded.
- DATA: sample every `BAUD_DIV` cycles, 8 bits, LSB first.
- STOP: sample once after `BAUD_DIV` cycles.
  - High and FIFO not full: push the byte.
  - High and FIFO full: drop the byte, set `overrun`.
  - Low: drop the byte, set `frame_err`.
- After STOP, return to IDLE and wait for the next falling edge.

**FIFO**
- Circular buffer with wrapping read/write pointers and a count of 0..`FIFO_DEPTH`.
- Push and pop in the same cycle both happen; count is unchanged.
- A pop when full makes room for a same-cycle push.

## Timing
- Reset values:
  - `uart_TxD`=1, `ack_o`=0, `data_o`=0, `irq_o`=0.
  - FIFO empty, pointers 0, sticky bits 0, `tx_ready`=1.
  - Both FSMs in IDLE; synchronizer flops at 1.
- Reset mid-frame aborts TX (line returns high immediately after the reset edge) and RX, and discards FIFO contents.
- Read latency: 1 cycle from the accepting edge to `ack_o`/`data_o`.
- TX start bit begins on `uart_TxD` at the accepting edge of the DATA write. Total frame length is `10*BAUD_DIV` cycles.
- RX push occurs `2 + BAUD_DIV/2 + 9*BAUD_DIV` cycles after the falling edge reaches the pin, ±1 cycle.
- `irq_o` and `rx_valid` follow the count with 1 cycle of registered delay at most. `irq_o` falls in the cycle after the pop that empties the FIFO.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles with random inputs -> all outputs at reset values; STATUS read returns 0x00000001.
- **TX:** `BAUD_DIV`=4, write DATA=0x55 -> `uart_TxD` shows 0,1,0,1,0,1,0,1,0,1, each for 4 cycles; `tx_ready`=0 for 40 cycles. A second write during the frame is dropped and acked.
- **RX + readback:**
  - Drive frame 0xA3 into `uart_RxD` -> `irq_o`=1 and STATUS=0x00000012.
  - DATA read -> 0x000000A3; then `irq_o`=0.
  - Another DATA read -> 0x00000000.
- **Overrun:** send 5 frames 0x01..0x05 without reading -> STATUS=0x00000046. DATA reads return 0x01..0x04. A subsequent STATUS read shows `overrun` cleared.
- **Framing/glitch:**
  - Frame 0x7E with stop bit low -> nothing pushed, `frame_err`=1.
  - 1-cycle low pulse on `uart_RxD` -> no push, no error.
- **Simultaneous push/pop:** FIFO full (4 entries), time the DATA read to coincide with the stop-bit push -> count stays 4, no overrun, order preserved.
